// File: rtl/mtr_duty_gen.sv
// ============================================================================
// Module   : mtr_duty_gen
// Purpose  : Signed wheel-speed commands to clamped 11-bit PWM duty words,
//            updated only at PWM-period boundaries. Optional slew limiting
//            is enabled by defining MTR_RAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mtr_duty_gen #(
    parameter logic [10:0] DUTY_MIN  = 11'h020,
    parameter logic [10:0] DUTY_MAX  = 11'h7E0
`ifdef MTR_RAMP_EN
    ,
    parameter logic [10:0] RAMP_STEP = 11'd16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spd_vld,
    input  logic [11:0] lft_spd,
    input  logic [11:0] rght_spd,
    output logic [10:0] lft_duty,
    output logic [10:0] rght_duty,
    output logic        period_strt,
    output logic        at_tgt
);

    localparam logic [10:0] c_DUTY_RST = 11'h400;

    logic [10:0]       r_cnt;
    logic              r_period_strt;
    logic              w_bnd;
    logic [1:0][11:0]  w_spd;
    logic [1:0][10:0]  w_duty;
    logic [1:0]        w_match;

    assign w_bnd = (r_cnt == 11'h7FF);
    assign w_spd = {rght_spd, lft_spd};

    // Free-running period counter, phase-aligned with the PWM counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= 11'd0;
            r_period_strt <= 1'b0;
        end else begin
            r_cnt         <= r_cnt + 11'd1;
            r_period_strt <= w_bnd;
        end
    end

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_ch
            logic signed [11:0] w_t;
            logic [10:0]        w_map;
            logic [10:0]        w_next;
            logic [10:0]        r_tgt;
            logic [10:0]        r_duty;

            // Offset-binary: spd/2 centred on 50 %; result is always 0..2047.
            assign w_t = 12'sh400 + ($signed(w_spd[g]) >>> 1);

            always_comb begin
                w_map = w_t[10:0];
                if (w_t < {1'b0, DUTY_MIN})
                    w_map = DUTY_MIN;
                else if (w_t > {1'b0, DUTY_MAX})
                    w_map = DUTY_MAX;
            end

`ifdef MTR_RAMP_EN
            localparam logic signed [11:0] c_STEP = $signed({1'b0, RAMP_STEP});
            logic signed [11:0] w_diff;

            assign w_diff = $signed({1'b0, r_tgt}) - $signed({1'b0, r_duty});

            always_comb begin
                w_next = r_tgt;
                if (w_diff > c_STEP)
                    w_next = r_duty + RAMP_STEP;
                else if (w_diff < -c_STEP)
                    w_next = r_duty - RAMP_STEP;
            end
`else
            assign w_next = r_tgt;
`endif

            // Duty samples the pre-edge target, so a strobe on the boundary
            // cycle only takes effect at the following boundary.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tgt  <= c_DUTY_RST;
                    r_duty <= c_DUTY_RST;
                end else begin
                    if (spd_vld)
                        r_tgt <= w_map;
                    if (w_bnd)
                        r_duty <= w_next;
                end
            end

            assign w_duty[g]  = r_duty;
            assign w_match[g] = (r_duty == r_tgt);
        end
    endgenerate

    assign lft_duty    = w_duty[0];
    assign rght_duty   = w_duty[1];
    assign period_strt = r_period_strt;
    assign at_tgt      = &w_match;

endmodule

`default_nettype wire

// File: doc/mtr_duty_gen.md
# mtr_duty_gen

Speed-command-to-duty stage placed directly upstream of the two 11-bit PWM generators (left and right motor). It converts signed 12-bit wheel-speed commands into offset-binary 11-bit duty words, clamps them away from 0 %/100 %, optionally slew-limits them, and updates them only at PWM-period boundaries so the downstream comparator never sees a mid-period duty change.

## Interface
- DUTY_MIN, 11'h020: lowest duty ever driven (keeps bootstrap high-side alive).
- DUTY_MAX, 11'h7E0: highest duty ever driven.
- RAMP_STEP, 11'd16: maximum duty change per PWM period per channel (ramp build only).

- clk  in  1  system clock, shared with the PWM generators.
- rst  in  1  asynchronous, active-high reset.
- spd_vld  in  1  single-cycle strobe; captures lft_spd/rght_spd.
- lft_spd  in  12  signed left wheel speed command, two's complement.
- rght_spd  in  12  signed right wheel speed command, two's complement.
- lft_duty  out  11  duty word to left PWM generator.
- rght_duty  out  11  duty word to right PWM generator.
- period_strt  out  1  one-cycle pulse on the cycle the duty registers update.
- at_tgt  out  1  high when both duty outputs equal their clamped targets.

## Operation
- Period counter: 11-bit free-running, 0 on reset, +1 every clk, wraps 2047->0; identical cadence to the PWM counter, so both are phase-aligned after a common reset.
- Target capture: on spd_vld, lft_tgt/rght_tgt <= map(spd). Capture allowed in any cycle; last strobe before a boundary wins.
- map(spd): t = 12'sh400 + (spd >>> 1), computed 12-bit signed (range 0..2047, no overflow); then clamp to [DUTY_MIN, DUTY_MAX]; result 11 bits. spd=0 -> 0x400 (zero speed, 50 %).
- Duty update: only on the edge where counter==2047 (ramp or jump per Configuration); new duty valid when counter==0.
- period_strt: registered, high for the single cycle following that edge (counter==0).
- at_tgt: combinational compare (lft_duty==lft_tgt) && (rght_duty==rght_tgt).
- Channels are independent; identical logic instantiated twice or generated.

## Timing
- Reset values: lft_duty=rght_duty=11'h400, targets=11'h400, counter=0, period_strt=0, at_tgt=1.
- Reset asserted mid-period: all state returns to reset values immediately (async); after release counter restarts at 0.
- Latency, non-ramp: spd_vld at cycle k -> duty changes on the next boundary edge; worst case 2048 cycles, best case 1 (strobe on the cycle counter==2047 is NOT used for that boundary; the boundary uses the pre-edge target, new target applies at the following boundary).
- Ramp: each boundary, if |tgt-duty| <= RAMP_STEP then duty<=tgt, else duty moves RAMP_STEP toward tgt. Difference computed 12-bit signed, no wrap.
- Target change while ramping: ramp direction re-evaluated at the next boundary against the new target; no reversal glitch within a period.
- Duty outputs never outside [DUTY_MIN, DUTY_MAX] after first boundary; reset value 0x400 lies inside.

## Configuration
- MTR_RAMP_EN defined: slew limiting per RAMP_STEP as above.
- MTR_RAMP_EN undefined: duty <= tgt in one step at each boundary; RAMP_STEP ignored; at_tgt low at most until the next boundary after a capture.

## Test plan
- Reset: assert rst mid-run with duty=0x600 -> same cycle lft_duty=rght_duty=0x400, at_tgt=1; after release period_strt first pulses 2048 cycles later.
- Mapping/clamp (no ramp): lft_spd=12'sh7FF, rght_spd=12'sh800 -> after boundary lft_duty=0x7E0 (clamped from 0x7FF), rght_duty=0x020 (clamped from 0x000); spd=12'sh100 -> 0x480.
- Boundary hold: spd_vld with lft_spd=12'sh200 at counter==5 -> lft_duty stays 0x400 through counter==2047, becomes 0x500 when counter==0, period_strt high that cycle.
- Strobe at boundary: spd_vld on counter==2047 cycle -> duty unchanged at that boundary, updated at the next one.
- Ramp (MTR_RAMP_EN, RAMP_STEP=16): 0x400 -> target 0x440 -> duties 0x410, 0x420, 0x430, 0x440 on four successive boundaries; at_tgt rises with the last.
- Ramp reversal: mid-ramp at 0x420 retarget to spd=-64 (tgt 0x3E0) -> next boundaries 0x410, 0x400, 0x3F0, 0x3E0.
